eth_sw_sched: RTL and testbench
===============================

Name: eth_sw_sched

Overview:
- Crossbar scheduler for the 2x2 switch. It pops packet words from the two ingress FIFOs (port A and port B, one per rx FSM) and steers each word by destination address to one of two egress output registers.
- Each egress has its own round-robin arbiter, used when both ingress heads target the same egress.
- Words with an unknown destination, or with sop clear, are dropped and counted.
- It sits between the per-port ingress FIFOs and the egress tx logic.

Parameters:
- PORT_A_ADDR, 32'hABCD, destination address served by egress A
- PORT_B_ADDR, 32'hEFEF, destination address served by egress B
- CNT_W, 16, width of the drop counter

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- sched_en  in  1  when 0, no new grants or drops; registered outputs still drain
- ina_empty  in  1  ingress FIFO A empty (first-word-fall-through)
- ina_data  in  67  ingress FIFO A head word
- ina_rd_en  out  1  pop ingress FIFO A
- inb_empty  in  1  ingress FIFO B empty
- inb_data  in  67  ingress FIFO B head word
- inb_rd_en  out  1  pop ingress FIFO B
- outa_valid  out  1  egress A word valid
- outa_data  out  67  egress A word
- outa_ready  in  1  egress A consumer accepts
- outb_valid  out  1  egress B word valid
- outb_data  out  67  egress B word
- outb_ready  in  1  egress B consumer accepts
- drop_cnt  out  CNT_W  saturating count of dropped words

Behaviour:
- Word format:
  - [0] sop
  - [32:1] dest addr
  - [64:33] data
  - [65] eop
  - [66] reserved; passed through unchanged
- Reset (asynchronous, rstn=0): outa/outb_valid=0, outa/outb_data=0, drop_cnt=0, both round-robin pointers point to ingress A. rd_en outputs are combinational and forced 0 while rstn=0.
- Head classification, per ingress i, valid only when !in*_empty and sched_en=1:
  - DROP if sop=0, or if dest is neither PORT_A_ADDR nor PORT_B_ADDR.
  - Otherwise a request to egress A (dest==PORT_A_ADDR) or egress B (dest==PORT_B_ADDR).
- Egress slot free: slot_e = !out*_valid | out*_ready. The register may reload in the same cycle the consumer takes the old word.
- Arbitration, per egress, each cycle:
  - One requester with slot free: grant it.
  - Two requesters with slot free: grant the input named by rr_ptr_e. rr_ptr_e flips to the other input only on a contested grant. An uncontested grant leaves the pointer unchanged.
  - Slot not free: no grant; heads stay in the FIFOs (backpressure).
- Egresses arbitrate independently: A→egA and B→egB can both be granted in the same cycle.
- Pop: in*_rd_en=1 combinationally in the cycle its head is granted or classified DROP. At most one pop per ingress per cycle.
- Drops:
  - A drop never waits on egress state.
  - drop_cnt increments by 1 per dropped word and saturates at all-ones.
  - Two drops in the same cycle add 2, saturating.
- Egress register:
  - On grant at edge N, out*_data/out*_valid update at edge N. Latency from head visible to out*_valid is 1 cycle.
  - When out*_valid=1 and out*_ready=0, out*_data holds stable.
  - When valid & ready and there is no new grant, valid clears at the next edge.
- Each egress register behaves as two states, EMPTY and FULL:
  - EMPTY→FULL on grant.
  - FULL→FULL on ready & grant (reload).
  - FULL→EMPTY on ready & !grant.
  - FULL holds on !ready.
- sched_en=0: no rd_en asserted, no pointer or counter change. A word already held in an egress register is still delivered on ready.
- Reset mid-operation: held egress words are discarded, no FIFO pop occurs, pointers return to A.

Test Plan:
- Reset, then A head = {sop=1, dest=ABCD, data=1234, eop=1}, B empty, both ready=1 → ina_rd_en=1 for 1 cycle; next cycle outa_valid=1 with identical 67-bit word; outb_valid=0; drop_cnt=0.
- Both heads dest=EFEF, 4 words each, outb_ready=1 → egress B sequence A,B,A,B,A,B,A,B; one pop per cycle; outa_valid stays 0.
- A→ABCD and B→EFEF simultaneously → both rd_en=1 in the same cycle; both outputs valid next cycle.
- outa_ready=0 for 5 cycles with A head dest=ABCD → first word held stable, ina_rd_en=0 while held; the second word appears on the cycle after ready rises.
- A head dest=1234, B head sop=0 dest=ABCD → both popped in the same cycle, drop_cnt=2, no output valid. Preload drop_cnt to 0xFFFF via 65535 drops, then one more drop → drop_cnt stays 0xFFFF.
- Async rstn low mid-stall with outa_valid=1 → outa_valid=0 immediately, without waiting for a clk edge; after release, contested EFEF requests grant A first.

Source files
------------

// File: rtl/eth_sw_sched.sv
// Crossbar scheduler for the 2x2 switch: pops ingress FIFO heads, steers each word
// by destination into one of two egress registers, and counts dropped words.
module eth_sw_sched #(
    parameter logic [31:0] PORT_A_ADDR = 32'hABCD,
    parameter logic [31:0] PORT_B_ADDR = 32'hEFEF,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sched_en,
    input  logic             ina_empty,
    input  logic [66:0]      ina_data,
    output logic             ina_rd_en,
    input  logic             inb_empty,
    input  logic [66:0]      inb_data,
    output logic             inb_rd_en,
    output logic             outa_valid,
    output logic [66:0]      outa_data,
    input  logic             outa_ready,
    output logic             outb_valid,
    output logic [66:0]      outb_data,
    input  logic             outb_ready,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic {EMPTY, FULL} slot_t;

    slot_t state_a, state_a_nxt;
    slot_t state_b, state_b_nxt;

    // Round-robin pointers: 0 selects ingress A, 1 selects ingress B.
    logic ptr_a, ptr_b;

    logic head_a_ok, head_b_ok;
    logic a_to_a, a_to_b, b_to_a, b_to_b;
    logic drop_a, drop_b;
    logic slot_a, slot_b;
    logic gnt_ea_from_a, gnt_ea_from_b, gnt_eb_from_a, gnt_eb_from_b;
    logic gnt_ea, gnt_eb;
    logic contest_ea, contest_eb;
    logic [1:0] drop_inc;
    logic [CNT_W:0] cnt_sum;

    assign head_a_ok = !ina_empty && sched_en;
    assign head_b_ok = !inb_empty && sched_en;

    assign a_to_a = head_a_ok && ina_data[0] && (ina_data[32:1] == PORT_A_ADDR);
    assign a_to_b = head_a_ok && ina_data[0] && (ina_data[32:1] == PORT_B_ADDR);
    assign b_to_a = head_b_ok && inb_data[0] && (inb_data[32:1] == PORT_A_ADDR);
    assign b_to_b = head_b_ok && inb_data[0] && (inb_data[32:1] == PORT_B_ADDR);

    assign drop_a = head_a_ok && !(a_to_a || a_to_b);
    assign drop_b = head_b_ok && !(b_to_a || b_to_b);

    // The egress register may reload in the same cycle its consumer takes the old word.
    assign slot_a = (state_a == EMPTY) || outa_ready;
    assign slot_b = (state_b == EMPTY) || outb_ready;

    assign contest_ea    = slot_a && a_to_a && b_to_a;
    assign gnt_ea_from_a = slot_a && a_to_a && (!b_to_a || !ptr_a);
    assign gnt_ea_from_b = slot_a && b_to_a && (!a_to_a || ptr_a);
    assign gnt_ea        = gnt_ea_from_a || gnt_ea_from_b;

    assign contest_eb    = slot_b && a_to_b && b_to_b;
    assign gnt_eb_from_a = slot_b && a_to_b && (!b_to_b || !ptr_b);
    assign gnt_eb_from_b = slot_b && b_to_b && (!a_to_b || ptr_b);
    assign gnt_eb        = gnt_eb_from_a || gnt_eb_from_b;

    // A head targets at most one egress, so each ingress pops at most once per cycle.
    assign ina_rd_en = rstn && (drop_a || gnt_ea_from_a || gnt_eb_from_a);
    assign inb_rd_en = rstn && (drop_b || gnt_ea_from_b || gnt_eb_from_b);

    assign outa_valid = (state_a == FULL);
    assign outb_valid = (state_b == FULL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_a <= EMPTY;
            state_b <= EMPTY;
        end else begin
            state_a <= state_a_nxt;
            state_b <= state_b_nxt;
        end
    end

    always_comb begin
        state_a_nxt = state_a;
        state_b_nxt = state_b;
        case (state_a)
            EMPTY:   if (gnt_ea) state_a_nxt = FULL;
            FULL:    if (outa_ready && !gnt_ea) state_a_nxt = EMPTY;
            default: state_a_nxt = EMPTY;
        endcase
        case (state_b)
            EMPTY:   if (gnt_eb) state_b_nxt = FULL;
            FULL:    if (outb_ready && !gnt_eb) state_b_nxt = EMPTY;
            default: state_b_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outa_data <= '0;
            outb_data <= '0;
        end else begin
            if (gnt_ea) outa_data <= gnt_ea_from_a ? ina_data : inb_data;
            if (gnt_eb) outb_data <= gnt_eb_from_a ? ina_data : inb_data;
        end
    end

    // Pointers move only when both inputs competed for the same egress.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_a <= 1'b0;
            ptr_b <= 1'b0;
        end else begin
            if (contest_ea) ptr_a <= !ptr_a;
            if (contest_eb) ptr_b <= !ptr_b;
        end
    end

    assign drop_inc = {1'b0, drop_a} + {1'b0, drop_b};
    assign cnt_sum  = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, drop_inc};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= '0;
        end else if (cnt_sum[CNT_W]) begin
            drop_cnt <= '1;
        end else begin
            drop_cnt <= cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_eth_sw_sched.sv
// Self-checking bench for eth_sw_sched: directed scenarios plus randomized traffic,
// all compared against a cycle reference model of the scheduling rules.
module tb_eth_sw_sched;

    localparam logic [31:0] ADDR_A = 32'hABCD;
    localparam logic [31:0] ADDR_B = 32'hEFEF;
    localparam int          CNT_MAX = 65535;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        sched_en = 1'b0;
    logic        ina_empty = 1'b1;
    logic [66:0] ina_data = '0;
    logic        ina_rd_en;
    logic        inb_empty = 1'b1;
    logic [66:0] inb_data = '0;
    logic        inb_rd_en;
    logic        outa_valid;
    logic [66:0] outa_data;
    logic        outa_ready = 1'b1;
    logic        outb_valid;
    logic [66:0] outb_data;
    logic        outb_ready = 1'b1;
    logic [15:0] drop_cnt;

    logic [66:0] qa[$];
    logic [66:0] qb[$];

    logic        m_v[2];
    logic [66:0] m_d[2];
    int          m_ptr[2];
    int          m_cnt;

    logic obs_rda, obs_rdb;
    int   n_vec = 0;
    int   n_err = 0;

    eth_sw_sched dut (
        .clk        (clk),
        .rstn       (rstn),
        .sched_en   (sched_en),
        .ina_empty  (ina_empty),
        .ina_data   (ina_data),
        .ina_rd_en  (ina_rd_en),
        .inb_empty  (inb_empty),
        .inb_data   (inb_data),
        .inb_rd_en  (inb_rd_en),
        .outa_valid (outa_valid),
        .outa_data  (outa_data),
        .outa_ready (outa_ready),
        .outb_valid (outb_valid),
        .outb_data  (outb_data),
        .outb_ready (outb_ready),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [66:0] mk(input logic sop, input logic [31:0] dest,
                                       input logic [31:0] data, input logic eop);
        logic rsv;
        rsv = 1'($urandom_range(0, 1));
        return {rsv, eop, data, dest, sop};
    endfunction

    // 0 = egress A, 1 = egress B, 2 = drop
    function automatic int classify(input logic [66:0] w);
        if (!w[0]) return 2;
        if (w[32:1] == ADDR_A) return 0;
        if (w[32:1] == ADDR_B) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        for (int e = 0; e < 2; e++) begin
            m_v[e]   = 1'b0;
            m_d[e]   = '0;
            m_ptr[e] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic drive_heads();
        ina_empty = (qa.size() == 0);
        ina_data  = (qa.size() != 0) ? qa[0] : '0;
        inb_empty = (qb.size() == 0);
        inb_data  = (qb.size() != 0) ? qb[0] : '0;
    endtask

    // One clock cycle: predict pops and next egress contents from the scheduling
    // rules, check rd_en mid-cycle and registered outputs just after the edge.
    task automatic step();
        int          c[2];
        int          g;
        logic        pop[2];
        logic        rdy[2];
        logic        nv[2];
        logic [66:0] nd[2];
        logic [66:0] head[2];
        int          drops;
        drive_heads();
        @(negedge clk);
        head[0] = ina_data;
        head[1] = inb_data;
        rdy[0]  = outa_ready;
        rdy[1]  = outb_ready;
        drops   = 0;
        for (int i = 0; i < 2; i++) begin
            pop[i] = 1'b0;
            c[i]   = 3;
            if (sched_en && ((i == 0) ? qa.size() != 0 : qb.size() != 0)) c[i] = classify(head[i]);
            if (c[i] == 2) begin
                pop[i] = 1'b1;
                drops++;
            end
        end
        for (int e = 0; e < 2; e++) begin
            g     = -1;
            nv[e] = m_v[e];
            nd[e] = m_d[e];
            if (!m_v[e] || rdy[e]) begin
                if (c[0] == e && c[1] == e) begin
                    g        = m_ptr[e];
                    m_ptr[e] = 1 - m_ptr[e];
                end else if (c[0] == e) begin
                    g = 0;
                end else if (c[1] == e) begin
                    g = 1;
                end
            end
            if (g >= 0) begin
                nv[e]  = 1'b1;
                nd[e]  = head[g];
                pop[g] = 1'b1;
            end else if (rdy[e]) begin
                nv[e] = 1'b0;
            end
        end
        m_cnt   = (m_cnt + drops > CNT_MAX) ? CNT_MAX : m_cnt + drops;
        obs_rda = ina_rd_en;
        obs_rdb = inb_rd_en;
        n_vec += 2;
        if (obs_rda !== pop[0]) begin
            n_err++;
            $display("[TB] FAIL ina_rd_en: got %b expected %b at %0t", obs_rda, pop[0], $time);
        end
        if (obs_rdb !== pop[1]) begin
            n_err++;
            $display("[TB] FAIL inb_rd_en: got %b expected %b at %0t", obs_rdb, pop[1], $time);
        end
        @(posedge clk);
        #1;
        if (pop[0] && qa.size() != 0) void'(qa.pop_front());
        if (pop[1] && qb.size() != 0) void'(qb.pop_front());
        m_v = nv;
        m_d = nd;
        n_vec += 5;
        if (outa_valid !== m_v[0]) begin
            n_err++;
            $display("[TB] FAIL outa_valid: got %b expected %b at %0t", outa_valid, m_v[0], $time);
        end
        if (outa_data !== m_d[0]) begin
            n_err++;
            $display("[TB] FAIL outa_data: got %h expected %h at %0t", outa_data, m_d[0], $time);
        end
        if (outb_valid !== m_v[1]) begin
            n_err++;
            $display("[TB] FAIL outb_valid: got %b expected %b at %0t", outb_valid, m_v[1], $time);
        end
        if (outb_data !== m_d[1]) begin
            n_err++;
            $display("[TB] FAIL outb_data: got %h expected %h at %0t", outb_data, m_d[1], $time);
        end
        if (drop_cnt !== 16'(m_cnt)) begin
            n_err++;
            $display("[TB] FAIL drop_cnt: got %0d expected %0d at %0t", drop_cnt, m_cnt, $time);
        end
        drive_heads();
    endtask

    task automatic do_reset();
        rstn       = 1'b0;
        sched_en   = 1'b1;
        outa_ready = 1'b1;
        outb_ready = 1'b1;
        qa.delete();
        qb.delete();
        drive_heads();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        qa.push_back(mk(1'b1, ADDR_A, 32'h1, 1'b1));
        drive_heads();
        sched_en = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        n_vec += 5;
        if (ina_rd_en !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_rd_en: got %b expected 0", ina_rd_en);
        end
        if (outa_valid !== 1'b0 || outb_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_valid: got %b%b expected 00", outa_valid, outb_valid);
        end
        if (outa_data !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_outa_data: got %h expected 0", outa_data);
        end
        if (outb_data !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_outb_data: got %h expected 0", outb_data);
        end
        if (drop_cnt !== 16'h0) begin
            n_err++;
            $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [66:0] w;
        do_reset();
        w = mk(1'b1, ADDR_A, 32'h1234, 1'b1);
        qa.push_back(w);
        step();
        n_vec += 3;
        if (obs_rda !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL single_pop: got %b expected 1", obs_rda);
        end
        if (outa_valid !== 1'b1 || outa_data !== w) begin
            n_err++;
            $display("[TB] FAIL single_out: got %b/%h expected 1/%h", outa_valid, outa_data, w);
        end
        if (outb_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL single_outb: got %b expected 0", outb_valid);
        end
        step();
        n_vec++;
        if (obs_rda !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL single_pop_once: got %b expected 0", obs_rda);
        end
    endtask

    task automatic test_contested();
        logic [31:0] exp_tag;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            qa.push_back(mk(1'b1, ADDR_B, 32'hA000 + i, 1'b0));
            qb.push_back(mk(1'b1, ADDR_B, 32'hB000 + i, 1'b0));
        end
        for (int k = 0; k < 8; k++) begin
            step();
            exp_tag = ((k % 2) == 0) ? 32'hA000 + k / 2 : 32'hB000 + k / 2;
            n_vec += 3;
            if (outb_valid !== 1'b1 || outb_data[64:33] !== exp_tag) begin
                n_err++;
                $display("[TB] FAIL rr_order[%0d]: got %b/%h expected 1/%h", k, outb_valid, outb_data[64:33], exp_tag);
            end
            if ((obs_rda ^ obs_rdb) !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL rr_one_pop[%0d]: got %b%b expected one pop", k, obs_rda, obs_rdb);
            end
            if (outa_valid !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL rr_outa_idle[%0d]: got %b expected 0", k, outa_valid);
            end
        end
    endtask

    task automatic test_parallel();
        do_reset();
        qa.push_back(mk(1'b1, ADDR_A, 32'h11, 1'b1));
        qb.push_back(mk(1'b1, ADDR_B, 32'h22, 1'b1));
        step();
        n_vec += 2;
        if (obs_rda !== 1'b1 || obs_rdb !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL parallel_pop: got %b%b expected 11", obs_rda, obs_rdb);
        end
        if (outa_valid !== 1'b1 || outb_valid !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL parallel_valid: got %b%b expected 11", outa_valid, outb_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [66:0] w1, w2;
        do_reset();
        w1 = mk(1'b1, ADDR_A, 32'h5555, 1'b0);
        w2 = mk(1'b1, ADDR_A, 32'h6666, 1'b1);
        qa.push_back(w1);
        qa.push_back(w2);
        outa_ready = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            n_vec += 2;
            if (outa_data !== w1 || outa_valid !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL hold_data[%0d]: got %b/%h expected 1/%h", k, outa_valid, outa_data, w1);
            end
            if (obs_rda !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL hold_no_pop[%0d]: got %b expected 0", k, obs_rda);
            end
        end
        outa_ready = 1'b1;
        step();
        n_vec++;
        if (outa_data !== w2 || outa_valid !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL reload: got %b/%h expected 1/%h", outa_valid, outa_data, w2);
        end
    endtask

    task automatic test_drops();
        do_reset();
        qa.push_back(mk(1'b1, 32'h1234, 32'h1, 1'b1));
        qb.push_back(mk(1'b0, ADDR_A, 32'h2, 1'b1));
        step();
        n_vec += 3;
        if (obs_rda !== 1'b1 || obs_rdb !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL drop_pop: got %b%b expected 11", obs_rda, obs_rdb);
        end
        if (drop_cnt !== 16'd2) begin
            n_err++;
            $display("[TB] FAIL drop_two: got %0d expected 2", drop_cnt);
        end
        if (outa_valid !== 1'b0 || outb_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL drop_no_out: got %b%b expected 00", outa_valid, outb_valid);
        end
    endtask

    task automatic test_saturate();
        int guard;
        do_reset();
        for (int i = 0; i < 32768; i++) qa.push_back(mk(1'b1, 32'h1234, 32'(i), 1'b0));
        for (int i = 0; i < 32767; i++) qb.push_back(mk(1'b0, ADDR_B, 32'(i), 1'b0));
        guard = 0;
        while ((qa.size() != 0 || qb.size() != 0) && guard < 40000) begin
            step();
            guard++;
        end
        n_vec += 2;
        if (guard >= 40000) begin
            n_err++;
            $display("[TB] FAIL sat_timeout: got %0d cycles expected < 40000", guard);
        end
        if (drop_cnt !== 16'hFFFF) begin
            n_err++;
            $display("[TB] FAIL sat_reach: got %h expected ffff", drop_cnt);
        end
        qa.push_back(mk(1'b0, ADDR_A, 32'h9, 1'b1));
        step();
        n_vec++;
        if (drop_cnt !== 16'hFFFF) begin
            n_err++;
            $display("[TB] FAIL sat_hold: got %h expected ffff", drop_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        qa.push_back(mk(1'b1, ADDR_A, 32'h77, 1'b0));
        qa.push_back(mk(1'b1, ADDR_A, 32'h78, 1'b0));
        outa_ready = 1'b0;
        step();
        step();
        #2;
        rstn = 1'b0;
        #1;
        n_vec += 2;
        if (outa_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL async_valid: got %b expected 0", outa_valid);
        end
        if (ina_rd_en !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL async_no_pop: got %b expected 0", ina_rd_en);
        end
        do_reset();
        qa.push_back(mk(1'b1, ADDR_B, 32'hAAAA, 1'b1));
        qb.push_back(mk(1'b1, ADDR_B, 32'hBBBB, 1'b1));
        step();
        n_vec++;
        if (outb_data[64:33] !== 32'hAAAA || obs_rda !== 1'b1 || obs_rdb !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL async_ptr: got %h pops %b%b expected aaaa pops 10", outb_data[64:33], obs_rda, obs_rdb);
        end
    endtask

    task automatic test_random();
        logic [31:0] dest;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 2) != 0 && ((i == 0) ? qa.size() : qb.size()) < 4) begin
                    case ($urandom_range(0, 4))
                        0, 1:    dest = ADDR_A;
                        2, 3:    dest = ADDR_B;
                        default: dest = $urandom;
                    endcase
                    if (i == 0) qa.push_back(mk(1'($urandom_range(0, 7) != 0), dest, $urandom, 1'($urandom_range(0, 1))));
                    else        qb.push_back(mk(1'($urandom_range(0, 7) != 0), dest, $urandom, 1'($urandom_range(0, 1))));
                end
            end
            outa_ready = 1'($urandom_range(0, 3) != 0);
            outb_ready = 1'($urandom_range(0, 3) != 0);
            sched_en   = 1'($urandom_range(0, 4) != 0);
            step();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contested();
        test_parallel();
        test_backpressure();
        test_drops();
        test_async_reset();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
